// File: rtl/prog_ram_loader.sv
// Writable 32x9 program store loaded over a valid/ready stream; 1-cycle registered fetch port.
// in_ready is high only in LOAD (one word per cycle); words offered in any other state are dropped.
module prog_ram_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 9,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              loading,
  output logic              loaded,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              xfer;
  logic [DATA_W-1:0] mem [DEPTH];

  assign in_ready = (state == ST_LOAD);
  assign loading  = (state == ST_LOAD);
  assign loaded   = (state == ST_DONE);
  assign load_err = (state == ST_ERR);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      word_count <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (xfer) begin
            wr_ptr     <= wr_ptr + ADDR_W'(1);
            word_count <= word_count + (ADDR_W+1)'(1);
            // The last-word flag wins over overflow: a full 32-word program is legal.
            if (in_last)
              state <= ST_DONE;
            else if (word_count == CNT_LAST)
              state <= ST_ERR;
          end
        end
        default: begin
          if (load_start) begin
            state      <= ST_LOAD;
            wr_ptr     <= '0;
            word_count <= '0;
          end
        end
      endcase
    end
  end

  // Memory has no reset so a loaded program survives a processor reset.
  always_ff @(posedge clk) begin
    if (xfer)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else
      rd_data <= mem[rd_addr];
  end

endmodule

// File: doc/prog_ram_loader.md
# prog_ram_loader

Writable program store that replaces the fixed instruction ROM when the processor must be reprogrammed. An external host streams 9-bit instruction words in over a valid/ready handshake; the block writes them into a 32 x 9 RAM starting at address 0 and then flags the program as loaded. The processor side fetches through a registered read port with the same one-cycle latency as the ROM, so the address counter and datapath connect unchanged.

## Interface
Parameters:
- ADDR_W, 5, address width of the store
- DATA_W, 9, instruction word width
- DEPTH, 32, number of words (2**ADDR_W)

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  one-cycle pulse; begins a new load from address 0
- in_valid  in  1  host word valid
- in_data  in  DATA_W  host instruction word
- in_last  in  1  marks the final word of the program; qualified by in_valid
- in_ready  out  1  block accepts a word this cycle
- rd_addr  in  ADDR_W  processor fetch address
- rd_data  out  DATA_W  registered fetch data
- loading  out  1  high while in LOAD
- loaded  out  1  a complete program is present
- load_err  out  1  program overflowed DEPTH without in_last
- word_count  out  ADDR_W+1  words accepted in the current/last load (0..32)

## Operation
- States: IDLE, LOAD, DONE, ERR. Encoded registers; outputs decoded from state.
- IDLE: in_ready=0. load_start -> LOAD; wr_ptr<=0, word_count<=0.
- LOAD: in_ready=1, loading=1. Transfer = in_valid & in_ready: mem[wr_ptr]<=in_data, wr_ptr<=wr_ptr+1, word_count<=word_count+1.
  - Transfer with in_last=1 -> DONE.
  - Transfer of 32nd word (word_count was 31) with in_last=0 -> ERR; wr_ptr wraps to 0, no further writes.
  - Transfer of 32nd word with in_last=1 -> DONE (full program, no error).
  - load_start while in LOAD: ignored.
- DONE: loaded=1, in_ready=0. load_start -> LOAD (loaded drops the next cycle, word_count<=0, wr_ptr<=0).
- ERR: load_err=1, in_ready=0, loaded=0. load_start -> LOAD (clears error).
- in_valid with in_ready=0 (IDLE/DONE/ERR): word dropped, no state change; host must hold it.
- Read port: rd_data<=mem[rd_addr] every clock in every state, independent of loading.
- Memory contents are not reset; previously loaded words survive reset and reloads until overwritten.

## Timing
- Reset values: state=IDLE, in_ready=0, loading=0, loaded=0, load_err=0, word_count=0, wr_ptr=0, rd_data=0.
- Reset mid-load: immediate return to IDLE; loaded stays 0; partially written words remain in memory.
- load_start sampled at rising edge; in_ready=1 from the following cycle.
- Write takes effect at the transfer edge; word visible on rd_data two edges after transfer (write edge, then read edge).
- Read latency: rd_data reflects rd_addr presented at the previous edge (1 cycle).
- Same-edge write and read of the same address: rd_data returns the old contents (read-before-write).
- loaded/load_err assert on the cycle after the terminating transfer.
- Maximum throughput: one word per cycle in LOAD.

## Test plan
- Reset, then load_start; stream 0x101, 0x0A2, 0x1FF with in_last on 0x1FF -> loaded=1 one cycle after third transfer, word_count=3; reads of addr 0,1,2 give 0x101, 0x0A2, 0x1FF one cycle after each address.
- Stream 32 words (value = index) with in_last on word 31 -> loaded=1, load_err=0, word_count=32; addr 31 reads 0x01F.
- Stream 32 words without in_last -> load_err=1, in_ready=0, word_count=32, loaded=0; 33rd in_valid not written (addr 0 still word 0); load_start clears load_err.
- Valid gaps and in_valid asserted in IDLE/DONE -> only LOAD-state transfers written; word_count counts transfers only.
- Assert rst after 5 of 10 words -> all flags 0, state IDLE; addrs 0..4 retain the written words.
- Read addr 3 on the same edge 0x155 is written to addr 3 (previous 0x0AA) -> rd_data=0x0AA, next read of addr 3 -> 0x155.
